// File: rtl/semaforo_ctrl.sv
// semaforo_ctrl: two-street traffic light FSM with pedestrian green shortening.
// Define SEMAFORO_NIGHT_MODE_EN to enable the flashing-yellow NIGHT state.
module semaforo_ctrl #(
  parameter int T_GREEN  = 8,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_SHORT  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enb,
  input  logic       ped_req_a,
  input  logic       ped_req_b,
  input  logic       night,
  output logic [1:0] semA,
  output logic [1:0] semB,
  output logic [2:0] state
);
  localparam int TMAX = T_GREEN > T_YELLOW ? (T_GREEN > T_ALLRED ? T_GREEN : T_ALLRED)
                                           : (T_YELLOW > T_ALLRED ? T_YELLOW : T_ALLRED);
  localparam int CW = $clog2(TMAX + 1);
  localparam logic [CW-1:0] SHORT = CW'(T_SHORT - 1);
`ifdef SEMAFORO_NIGHT_MODE_EN
  localparam bit NM = 1'b1;
`else
  localparam bit NM = 1'b0;
`endif
  typedef enum logic [2:0] {
    A_GREEN = 3'd0, A_YELLOW = 3'd1, ALLRED_1 = 3'd2, B_GREEN = 3'd3,
    B_YELLOW = 3'd4, ALLRED_2 = 3'd5, NIGHT = 3'd6
  } st_t;
  st_t st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic pend_a, pend_b, pend_a_nx, pend_b_nx, req_a, req_b, expired, go_night;
  logic [1:0] sem_a_nx, sem_b_nx;
`ifdef SEMAFORO_NIGHT_MODE_EN
  logic blink, blink_nx;
`endif
  function automatic logic [CW-1:0] dwell(st_t s);
    return s inside {A_GREEN, B_GREEN} ? CW'(T_GREEN - 1) :
           s inside {A_YELLOW, B_YELLOW, NIGHT} ? CW'(T_YELLOW - 1) : CW'(T_ALLRED - 1);
  endfunction
  assign state = st;
  always_comb begin
    req_a     = pend_a | ped_req_a;
    req_b     = pend_b | ped_req_b;
    expired   = cnt == '0;
    go_night  = night & NM;
    st_nx     = st;
    cnt_nx    = cnt - 1'b1;
    pend_a_nx = req_a;
    pend_b_nx = req_b;
`ifdef SEMAFORO_NIGHT_MODE_EN
    blink_nx  = blink;
`endif
    case (st)
      A_GREEN:  if (expired) st_nx = A_YELLOW; else if (req_a && cnt > SHORT) cnt_nx = SHORT;
      A_YELLOW: if (expired) st_nx = ALLRED_1;
      ALLRED_1: if (expired) st_nx = go_night ? NIGHT : B_GREEN;
      B_GREEN:  if (expired) st_nx = B_YELLOW; else if (req_b && cnt > SHORT) cnt_nx = SHORT;
      B_YELLOW: if (expired) st_nx = ALLRED_2;
      ALLRED_2: if (expired) st_nx = go_night ? NIGHT : A_GREEN;
`ifdef SEMAFORO_NIGHT_MODE_EN
      NIGHT: begin
        if (!night) st_nx = ALLRED_2;
        else if (expired) begin
          blink_nx = ~blink;
          cnt_nx   = dwell(NIGHT);
        end
      end
`endif
      default:  st_nx = ALLRED_2;
    endcase
    if (st_nx != st) cnt_nx = dwell(st_nx);
    // a request in the very cycle a green is entered survives the clear
    if (st_nx == B_GREEN && st != B_GREEN) pend_a_nx = ped_req_a;
    if (st_nx == A_GREEN && st != A_GREEN) pend_b_nx = ped_req_b;
    if (st_nx == NIGHT) {pend_a_nx, pend_b_nx} = 2'b00;
    sem_a_nx = st_nx == A_GREEN ? 2'b10 : st_nx == A_YELLOW ? 2'b01 : 2'b00;
    sem_b_nx = st_nx == B_GREEN ? 2'b10 : st_nx == B_YELLOW ? 2'b01 : 2'b00;
`ifdef SEMAFORO_NIGHT_MODE_EN
    if (st_nx == NIGHT && st != NIGHT) blink_nx = 1'b1;
    if (st_nx == NIGHT) {sem_a_nx, sem_b_nx} = {1'b0, blink_nx, 1'b0, blink_nx};
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= A_GREEN;
      cnt    <= dwell(A_GREEN);
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      semA   <= 2'b10;
      semB   <= 2'b00;
`ifdef SEMAFORO_NIGHT_MODE_EN
      blink  <= 1'b0;
`endif
    end else if (enb) begin
      st     <= st_nx;
      cnt    <= cnt_nx;
      pend_a <= pend_a_nx;
      pend_b <= pend_b_nx;
      semA   <= sem_a_nx;
      semB   <= sem_b_nx;
`ifdef SEMAFORO_NIGHT_MODE_EN
      blink  <= blink_nx;
`endif
    end
  end
endmodule

// File: tb/tb_semaforo_ctrl.sv
// tb_semaforo_ctrl: directed checks of sequencing, pedestrian shortening,
// enable gating, async reset and (when SEMAFORO_NIGHT_MODE_EN is defined) night mode.
module tb_semaforo_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, enb = 1'b1, ped_req_a = 1'b0, ped_req_b = 1'b0, night = 1'b0;
  logic [1:0] sem_a, sem_b;
  logic [2:0] state;
  int n_chk = 0, n_fail = 0;
  semaforo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enb(enb), .ped_req_a(ped_req_a), .ped_req_b(ped_req_b),
    .night(night), .semA(sem_a), .semB(sem_b), .state(state)
  );
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // {state, semA, semB} for cycle i of the 26-cycle free-running period
  function automatic logic [6:0] exp_obs(input int i);
    int k = i % 26;
    return k < 8 ? {3'd0, 2'b10, 2'b00} : k < 11 ? {3'd1, 2'b01, 2'b00} :
           k < 13 ? {3'd2, 2'b00, 2'b00} : k < 21 ? {3'd3, 2'b00, 2'b10} :
           k < 24 ? {3'd4, 2'b00, 2'b01} : {3'd5, 2'b00, 2'b00};
  endfunction
  task automatic test_reset;
    #12;
    n_chk++;
    if ({state, sem_a, sem_b} !== {3'd0, 2'b10, 2'b00}) begin
      n_fail++; $display("FAIL reset_outputs got %b want %b", {state, sem_a, sem_b}, 7'b000_10_00);
    end
    n_chk++;
    if ({dut.cnt, dut.pend_a, dut.pend_b} !== {4'd7, 2'b00}) begin
      n_fail++; $display("FAIL reset_internal got cnt=%0d pend=%b%b want cnt=7 pend=00", dut.cnt, dut.pend_a, dut.pend_b);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_free_run;
    for (int i = 0; i <= 26; i++) begin
      n_chk++;
      if ({state, sem_a, sem_b} !== exp_obs(i)) begin
        n_fail++; $display("FAIL free_run cycle %0d got %b want %b", i, {state, sem_a, sem_b}, exp_obs(i));
      end
      if (i < 26) step();
    end
  endtask
  task automatic test_ped_short;
    step();
    ped_req_a = 1'b1;
    step();
    ped_req_a = 1'b0;
    n_chk++;
    if ({state, dut.pend_a} !== {3'd0, 1'b1}) begin
      n_fail++; $display("FAIL ped_latch got state=%0d pend_a=%b want 0/1", state, dut.pend_a);
    end
    step();
    n_chk++;
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL ped_cycle3 got state=%0d want 0", state);
    end
    step();
    n_chk++;
    if ({state, sem_a} !== {3'd1, 2'b01}) begin
      n_fail++; $display("FAIL ped_shortened got state=%0d semA=%b want 1/01", state, sem_a);
    end
    step(4);
    n_chk++;
    if ({state, dut.pend_a} !== {3'd2, 1'b1}) begin
      n_fail++; $display("FAIL ped_pending got state=%0d pend_a=%b want 2/1", state, dut.pend_a);
    end
    step();
    n_chk++;
    if ({state, sem_b, dut.pend_a} !== {3'd3, 2'b10, 1'b0}) begin
      n_fail++; $display("FAIL ped_clear got state=%0d semB=%b pend_a=%b want 3/10/0", state, sem_b, dut.pend_a);
    end
  endtask
  task automatic test_expiry_collision;
    step(7);
    n_chk++;
    if (state !== 3'd3) begin
      n_fail++; $display("FAIL bgreen_full got state=%0d want 3", state);
    end
    ped_req_b = 1'b1;
    step();
    ped_req_b = 1'b0;
    n_chk++;
    if ({state, sem_b, dut.pend_b} !== {3'd4, 2'b01, 1'b1}) begin
      n_fail++; $display("FAIL collision got state=%0d semB=%b pend_b=%b want 4/01/1", state, sem_b, dut.pend_b);
    end
    step(4);
    n_chk++;
    if ({state, dut.pend_b} !== {3'd5, 1'b1}) begin
      n_fail++; $display("FAIL collision_pending got state=%0d pend_b=%b want 5/1", state, dut.pend_b);
    end
    step();
    n_chk++;
    if ({state, sem_a, dut.pend_b} !== {3'd0, 2'b10, 1'b0}) begin
      n_fail++; $display("FAIL collision_clear got state=%0d semA=%b pend_b=%b want 0/10/0", state, sem_a, dut.pend_b);
    end
  endtask
  task automatic test_enb_gating;
    step(9);
    enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if ({state, sem_a, sem_b, dut.cnt} !== {3'd1, 2'b01, 2'b00, 4'd1}) begin
        n_fail++; $display("FAIL enb_frozen %0d got state=%0d semA=%b cnt=%0d want 1/01/1", i, state, sem_a, dut.cnt);
      end
    end
    enb = 1'b1;
    step();
    n_chk++;
    if (state !== 3'd1) begin
      n_fail++; $display("FAIL enb_resume got state=%0d want 1", state);
    end
    step();
    n_chk++;
    if ({state, sem_a} !== {3'd2, 2'b00}) begin
      n_fail++; $display("FAIL enb_yellow_len got state=%0d semA=%b want 2/00", state, sem_a);
    end
  endtask
  task automatic test_async_reset;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({state, sem_a, sem_b, dut.cnt} !== {3'd0, 2'b10, 2'b00, 4'd7}) begin
      n_fail++; $display("FAIL async_reset got state=%0d semA=%b semB=%b cnt=%0d want 0/10/00/7", state, sem_a, sem_b, dut.cnt);
    end
    #3;
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_chk++;
      if (state !== (i < 8 ? 3'd0 : 3'd1)) begin
        n_fail++; $display("FAIL reset_dwell cycle %0d got state=%0d want %0d", i, state, i < 8 ? 0 : 1);
      end
    end
  endtask
`ifdef SEMAFORO_NIGHT_MODE_EN
  task automatic test_night;
    night = 1'b1;
    step(5);
    for (int j = 0; j <= 8; j++) begin
      n_chk++;
      if ({state, sem_a, sem_b} !== {3'd6, ((j / 3) % 2 == 0) ? 4'b0101 : 4'b0000}) begin
        n_fail++; $display("FAIL night_blink %0d got state=%0d semA=%b semB=%b", j, state, sem_a, sem_b);
      end
      if (j == 1) ped_req_a = 1'b1;
      if (j == 2) begin
        ped_req_a = 1'b0;
        n_chk++;
        if (dut.pend_a !== 1'b0) begin
          n_fail++; $display("FAIL night_pend got pend_a=%b want 0", dut.pend_a);
        end
      end
      if (j < 8) step();
    end
    night = 1'b0;
    step();
    n_chk++;
    if ({state, sem_a, sem_b} !== {3'd5, 4'b0000}) begin
      n_fail++; $display("FAIL night_exit got state=%0d semA=%b semB=%b want 5/00/00", state, sem_a, sem_b);
    end
    step(2);
    n_chk++;
    if ({state, sem_a} !== {3'd0, 2'b10}) begin
      n_fail++; $display("FAIL night_to_green got state=%0d semA=%b want 0/10", state, sem_a);
    end
  endtask
`else
  task automatic test_night;
    night = 1'b1;
    step(4);
    n_chk++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL night_allred got state=%0d want 2", state);
    end
    step();
    n_chk++;
    if ({state, sem_b} !== {3'd3, 2'b10}) begin
      n_fail++; $display("FAIL night_ignored got state=%0d semB=%b want 3/10", state, sem_b);
    end
    night = 1'b0;
  endtask
`endif
  initial begin
    test_reset();
    test_free_run();
    test_ped_short();
    test_expiry_collision();
    test_enb_gating();
    test_async_reset();
    test_night();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/semaforo_ctrl.md
SEMAFORO_CTRL -- requirements
Module: semaforo_ctrl

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- T_GREEN, 8, green dwell in enabled cycles (>=2).
- T_YELLOW, 3, yellow dwell in enabled cycles (>=1).
- T_ALLRED, 2, all-red clearance dwell in enabled cycles (>=1).
- T_SHORT, 2, remaining green after a pedestrian request (1..T_GREEN).
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- enb, input, 1, advance enable; 0 freezes all state.
- ped_req_a, input, 1, pedestrian request to cross street A.
- ped_req_b, input, 1, pedestrian request to cross street B.
- night, input, 1, night-mode request.
- semA, output, 2, light A: 00 red, 01 yellow, 10 green.
- semB, output, 2, light B, same encoding.
- state, output, 3, current FSM state code.
REQ-003 SHALL never drive code 11 on semA or semB.

Function
REQ-004 SHALL implement the FSM cycle A_GREEN(0) -> A_YELLOW(1) -> ALLRED_1(2) -> B_GREEN(3) -> B_YELLOW(4) -> ALLRED_2(5) -> A_GREEN, plus NIGHT(6); code 7 unused and SHALL recover to ALLRED_2.
REQ-005 SHALL drive registered outputs decoded from state: A_GREEN 10/00, A_YELLOW 01/00, ALLRED_x 00/00, B_GREEN 00/10, B_YELLOW 00/01 (semA/semB).
REQ-006 SHALL load a down-counter with T-1 on entering a state; on each enb=1 cycle: if 0, advance and load the next dwell, else decrement. Each state thus lasts exactly T enabled cycles.
REQ-007 SHALL hold state, counter and request flags unchanged while enb=0; inputs are sampled only when enb=1.
REQ-008 SHALL latch ped_req_a into flag pend_a, and ped_req_b into pend_b, on any enb=1 cycle.
REQ-009 SHALL, in A_GREEN with pend_a=1 and counter > T_SHORT-1, load the counter with T_SHORT-1 (one-time shortening). B_GREEN with pend_b behaves the same way.
REQ-010 SHALL clear pend_a on entry to B_GREEN and pend_b on entry to A_GREEN. A request arriving in the entry cycle SHALL stay latched.
REQ-011 SHALL give counter expiry priority over shortening in the same cycle. The request stays pending.
REQ-012 SHALL never shorten yellow or all-red dwells.
REQ-013 SHALL never show green on both streets in the same cycle, nor move green to yellow to green without an all-red state between.

Reset
REQ-014 SHALL, while rst_n=0 (asynchronously), force state=A_GREEN, counter=T_GREEN-1, pend_a=pend_b=0, semA=10, semB=00.
REQ-015 SHALL resume normal sequencing on the first enb=1 rising edge after rst_n deasserts. A reset mid-dwell discards the partial dwell.

Configuration
REQ-016 SHALL use macro SEMAFORO_NIGHT_MODE_EN. When it is defined:
- night=1 sampled at expiry of ALLRED_1 or ALLRED_2 enters NIGHT.
- In NIGHT, semA=semB toggles 01/00 every T_YELLOW enabled cycles, starting at 01.
- night=0 in NIGHT enters ALLRED_2 on the next enabled cycle.
- pend flags are cleared in NIGHT.
When it is undefined, the night port is ignored, NIGHT is unreachable, and code 6 recovers like code 7.

Verification (T_GREEN=8, T_YELLOW=3, T_ALLRED=2, T_SHORT=2, enb=1 unless stated)
REQ-017 SHALL cover the following directed scenarios:
- Free run from reset: semA=10 for 8 cycles, 01 for 3, then 00/00 for 2, then semB=10 for 8; full period 26 cycles.
- Pedestrian shortening: ped_req_a pulse at cycle 1 of A_GREEN -> A_GREEN ends after cycle 3 (2 cycles after the request); pend_a clears on B_GREEN entry.
- Expiry collision: ped_req_b pulse in the last B_GREEN cycle -> normal transition to B_YELLOW; pend_b=1 until A_GREEN entry.
- enb gating: enb=0 for 5 cycles in mid A_YELLOW -> outputs and counter frozen; A_YELLOW still totals 3 enabled cycles.
- Async reset: rst_n low mid B_GREEN, without a clock edge -> semA=10, semB=00, state=0 immediately.
- SEMAFORO_NIGHT_MODE_EN defined, night=1 -> NIGHT after the next all-red; semA=semB alternates 01/00 every 3 cycles. night=0 -> ALLRED_2 (2 cycles), then A_GREEN.
